// File: rtl/icache_sa_if.sv
// rtl/icache_sa_if.sv - CPU fetch and memory burst bus bundle for icache_sa
//
// Signals:
//   cache_ena, flush             - access mode and invalidate/abort pulse
//   s_araddr/s_arvalid/s_arready - CPU fetch request
//   s_rdata/s_rvalid             - CPU fetch response
//   m_araddr/m_arlen/m_arvalid/m_arready - memory burst request
//   m_rdata/m_rvalid/m_rlast/m_rready    - memory burst data
// Modports: slave = cache side, master = CPU/memory environment side.

interface icache_sa_if;
    logic        cache_ena;
    logic        flush;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rlast;
    logic        m_rready;

    modport slave (
        input  cache_ena, flush, s_araddr, s_arvalid,
        output s_arready, s_rdata, s_rvalid,
        output m_araddr, m_arlen, m_arvalid,
        input  m_arready, m_rdata, m_rvalid, m_rlast,
        output m_rready
    );

    modport master (
        output cache_ena, flush, s_araddr, s_arvalid,
        input  s_arready, s_rdata, s_rvalid,
        input  m_araddr, m_arlen, m_arvalid,
        output m_arready, m_rdata, m_rvalid, m_rlast,
        input  m_rready
    );
endinterface

// File: rtl/icache_sa.sv
// rtl/icache_sa.sv - set-associative instruction cache with burst refill and flush
//
// Ports:
//   clk  - clock, all state changes on rising edge
//   rst  - synchronous active-low reset
//   bus  - icache_sa_if.slave: CPU fetch request/response and memory burst channel
// Parameters: WAYS (1,2,4), SETS (power of two >= 2), LINE_WORDS (power of two 2..16).

module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 8
) (
    input  logic         clk,
    input  logic         rst,
    icache_sa_if.slave   bus
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] MISS_REQ = 3'd2;
    localparam logic [2:0] REFILL   = 3'd3;
    localparam logic [2:0] DRAIN    = 3'd4;

    logic [2:0]        state;
    logic [31:2]       req_addr;
    logic              req_cached;
    logic [WORD_W-1:0] beat_cnt;
    logic [WAY_W-1:0]  victim_q;
    logic [31:0]       capt_q;

    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              arvalid_q;
    logic [31:0]       araddr_q;
    logic [7:0]        arlen_q;

    logic              valid_q [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [31:0]       data_q  [WAYS][SETS][LINE_WORDS];
    logic [WAY_W-1:0]  ptr_q   [SETS];

    logic [WORD_W-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;

    assign req_word = req_addr[OFF_W-1:2];
    assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = req_addr[31:OFF_W+IDX_W];

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_c;
    logic [31:0]       hit_word;
    logic              take_beat;
    logic [31:0]       ret_word;
    logic              refill_write;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Walk downwards so the lowest-index invalid way wins; fall back to the
    // round-robin pointer only when the whole set is valid.
    always_comb begin
        victim_c = ptr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                victim_c = WAY_W'(w);
            end
        end
    end

    assign hit_word = data_q[hit_way][req_idx][req_word];

    // Uncached bursts are a single beat, so that beat is always the answer.
    assign take_beat    = !req_cached || (beat_cnt == req_word);
    assign ret_word     = take_beat ? bus.m_rdata : capt_q;
    assign refill_write = (state == REFILL) && bus.m_rvalid && req_cached && !bus.flush;

    assign bus.s_arready = (state == IDLE);
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.m_arvalid = arvalid_q;
    assign bus.m_araddr  = araddr_q;
    assign bus.m_arlen   = arlen_q;
    assign bus.m_rready  = (state == REFILL) || (state == DRAIN);

    // Tag and line data carry no reset; valid bits alone decide whether they matter.
    always_ff @(posedge clk) begin
        if (rst && refill_write) begin
            data_q[victim_q][req_idx][beat_cnt] <= bus.m_rdata;
            if (bus.m_rlast) begin
                tag_q[victim_q][req_idx] <= req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_cached <= 1'b0;
            beat_cnt   <= '0;
            victim_q   <= '0;
            capt_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else begin
            rvalid_q <= 1'b0;
            if (bus.flush) begin
                for (int w = 0; w < WAYS; w++) begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_q[w][s] <= 1'b0;
                    end
                end
                arvalid_q <= 1'b0;
                case (state)
                    // An address already accepted by memory leaves a burst to soak up.
                    MISS_REQ: state <= bus.m_arready ? DRAIN : IDLE;
                    REFILL, DRAIN: begin
                        if (bus.m_rvalid) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        state <= (bus.m_rvalid && bus.m_rlast) ? IDLE : DRAIN;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.s_arvalid) begin
                            req_addr   <= bus.s_araddr[31:2];
                            req_cached <= bus.cache_ena;
                            beat_cnt   <= '0;
                            if (bus.cache_ena) begin
                                state <= LOOKUP;
                            end else begin
                                state     <= MISS_REQ;
                                arvalid_q <= 1'b1;
                                araddr_q  <= bus.s_araddr;
                                arlen_q   <= '0;
                            end
                        end
                    end
                    LOOKUP: begin
                        if (hit) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= hit_word;
                            state    <= IDLE;
                        end else begin
                            victim_q  <= victim_c;
                            arvalid_q <= 1'b1;
                            araddr_q  <= {req_addr[31:OFF_W], {OFF_W{1'b0}}};
                            arlen_q   <= 8'(LINE_WORDS - 1);
                            state     <= MISS_REQ;
                        end
                    end
                    MISS_REQ: begin
                        if (bus.m_arready) begin
                            arvalid_q <= 1'b0;
                            beat_cnt  <= '0;
                            state     <= REFILL;
                        end
                    end
                    REFILL: begin
                        if (bus.m_rvalid) begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (take_beat) begin
                                capt_q <= bus.m_rdata;
                            end
                            if (bus.m_rlast) begin
                                rvalid_q <= 1'b1;
                                rdata_q  <= ret_word;
                                state    <= IDLE;
                                if (req_cached) begin
                                    valid_q[victim_q][req_idx] <= 1'b1;
                                    ptr_q[req_idx] <= (ptr_q[req_idx] == WAY_W'(WAYS - 1))
                                                      ? '0 : ptr_q[req_idx] + 1'b1;
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (bus.m_rvalid && bus.m_rlast) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// tb/tb_icache_sa.sv - self-checking scoreboard bench for icache_sa

module tb_icache_sa;

    logic clk;
    logic rst;

    icache_sa_if bus ();

    icache_sa #(.WAYS(2), .SETS(4), .LINE_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] sb_q [$];

    // Memory model: each beat returns its own word address.
    int          ar_count = 0;
    logic [31:0] ar_addr  = '0;
    logic [7:0]  ar_len   = '0;
    int          burst_taken = 0;
    int          beat_i = 0;
    bit          busy = 0;
    bit          arvalid_prev = 0;
    logic [31:0] araddr_prev = '0;
    logic [7:0]  arlen_prev = '0;
    bit          rready_prev = 0;

    initial begin
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rlast   = 1'b0;
        bus.m_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0;
                bus.m_arready = 1'b0;
                bus.m_rvalid  = 1'b0;
                bus.m_rlast   = 1'b0;
                arvalid_prev  = 0;
                rready_prev   = 0;
            end else begin
                if (bus.m_arready && arvalid_prev) begin
                    ar_count++;
                    ar_addr = araddr_prev;
                    ar_len  = arlen_prev;
                    busy = 1;
                    beat_i = 0;
                    burst_taken = 0;
                end else if (bus.m_rvalid && rready_prev) begin
                    burst_taken++;
                    beat_i++;
                    if (bus.m_rlast) busy = 0;
                end
                bus.m_arready = !busy && bus.m_arvalid;
                if (busy) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = ar_addr + 32'(beat_i * 4);
                    bus.m_rlast  = (beat_i == int'(ar_len));
                end else begin
                    bus.m_rvalid = 1'b0;
                    bus.m_rlast  = 1'b0;
                end
                arvalid_prev = bus.m_arvalid;
                araddr_prev  = bus.m_araddr;
                arlen_prev   = bus.m_arlen;
                rready_prev  = bus.m_rready;
            end
        end
    end

    // Response monitor and scoreboard.
    int cyc = 0;
    int rv_count = 0;
    int rv_cyc = 0;
    int arv_cycles = 0;

    initial begin
        logic [31:0] exp;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.m_arvalid) arv_cycles++;
            if (bus.s_rvalid) begin
                rv_count++;
                rv_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check("spurious_rvalid", 32'(bus.s_rvalid), 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("s_rdata", bus.s_rdata, exp);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic cached, input logic exp_miss);
        int base_cyc, ar0, arv0, rv0;
        ar0 = ar_count;
        arv0 = arv_cycles;
        rv0 = rv_count;
        base_cyc = cyc;
        sb_q.push_back(addr);
        bus.s_araddr  = addr;
        bus.cache_ena = cached;
        bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        for (int i = 0; i < 200 && rv_count == rv0; i++) step();
        check("rvalid_count", 32'(rv_count - rv0), 32'd1);
        if (rv_count == rv0) sb_q.delete();
        check("miss", 32'(ar_count != ar0), 32'(exp_miss));
        if (exp_miss) begin
            check("m_araddr", ar_addr, cached ? (addr & 32'hFFFF_FFE0) : addr);
            check("m_arlen", 32'(ar_len), cached ? 32'd7 : 32'd0);
        end else begin
            check("hit_latency", 32'(rv_cyc - base_cyc), 32'd2);
            check("hit_no_arvalid", 32'(arv_cycles - arv0), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0, rv0, arv0;
        rst = 1'b0;
        bus.cache_ena = 1'b1;
        bus.flush     = 1'b0;
        bus.s_araddr  = '0;
        bus.s_arvalid = 1'b0;
        repeat (3) step();
        check("rst_s_arready", 32'(bus.s_arready), 32'd1);
        check("rst_s_rvalid",  32'(bus.s_rvalid),  32'd0);
        check("rst_s_rdata",   bus.s_rdata,        32'd0);
        check("rst_m_arvalid", 32'(bus.m_arvalid), 32'd0);
        check("rst_m_araddr",  bus.m_araddr,       32'd0);
        check("rst_m_arlen",   32'(bus.m_arlen),   32'd0);
        check("rst_m_rready",  32'(bus.m_rready),  32'd0);
        rst = 1'b1;
        step();

        // Cold miss, then hit in the same line
        fetch(32'hF000_0000, 1'b1, 1'b1);
        fetch(32'hF000_0004, 1'b1, 1'b0);
        fetch(32'hF000_001C, 1'b1, 1'b0);

        // Three lines into index 0: third evicts way 0
        fetch(32'hF000_0080, 1'b1, 1'b1);
        fetch(32'hF000_0100, 1'b1, 1'b1);
        fetch(32'hF000_0088, 1'b1, 1'b0);
        fetch(32'hF000_0000, 1'b1, 1'b1);
        fetch(32'hF000_0104, 1'b1, 1'b0);

        // Uncached: exact address, single beat, never allocates
        fetch(32'h1FC0_0014, 1'b0, 1'b1);
        fetch(32'h1FC0_0014, 1'b0, 1'b1);

        // Flush after three refill beats: burst drained, nothing returned
        ar0 = ar_count;
        rv0 = rv_count;
        bus.s_araddr  = 32'hF000_0020;
        bus.cache_ena = 1'b1;
        bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        for (int i = 0; i < 100 && !(ar_count != ar0 && burst_taken >= 3); i++) step();
        check("flush_at_beat3", 32'(burst_taken), 32'd3);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 100 && busy; i++) step();
        check("drain_beats", 32'(burst_taken), 32'd8);
        check("drain_no_rvalid", 32'(rv_count - rv0), 32'd0);
        check("drain_s_arready", 32'(bus.s_arready), 32'd1);
        fetch(32'hF000_0020, 1'b1, 1'b1);

        // Flush with s_arvalid in the same cycle
        fetch(32'hF000_0040, 1'b1, 1'b1);
        fetch(32'hF000_0040, 1'b1, 1'b0);
        ar0 = ar_count;
        rv0 = rv_count;
        arv0 = arv_cycles;
        bus.s_araddr  = 32'hF000_0040;
        bus.s_arvalid = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        bus.flush     = 1'b0;
        repeat (4) step();
        check("flush_req_no_ar", 32'(arv_cycles - arv0), 32'd0);
        check("flush_req_no_mem", 32'(ar_count - ar0), 32'd0);
        check("flush_req_no_rvalid", 32'(rv_count - rv0), 32'd0);
        fetch(32'hF000_0040, 1'b1, 1'b1);

        // Reset mid-refill
        fetch(32'hF000_0060, 1'b1, 1'b1);
        fetch(32'hF000_0060, 1'b1, 1'b0);
        ar0 = ar_count;
        bus.s_araddr  = 32'hF000_0180;
        bus.s_arvalid = 1'b1;
        step();
        bus.s_arvalid = 1'b0;
        for (int i = 0; i < 100 && !(ar_count != ar0 && burst_taken >= 2); i++) step();
        check("rst_mid_refill_beats", 32'(burst_taken), 32'd2);
        rst = 1'b0;
        step();
        check("midrst_s_arready", 32'(bus.s_arready), 32'd1);
        check("midrst_s_rvalid",  32'(bus.s_rvalid),  32'd0);
        check("midrst_s_rdata",   bus.s_rdata,        32'd0);
        check("midrst_m_arvalid", 32'(bus.m_arvalid), 32'd0);
        check("midrst_m_araddr",  bus.m_araddr,       32'd0);
        check("midrst_m_arlen",   32'(bus.m_arlen),   32'd0);
        check("midrst_m_rready",  32'(bus.m_rready),  32'd0);
        rst = 1'b1;
        step();
        fetch(32'hF000_0060, 1'b1, 1'b1);
        fetch(32'hF000_0064, 1'b1, 1'b0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
